// File: rtl/fa_serial_ctrl.sv
// Bit-serial driver/collector for a registered full-adder cell: feeds operand bits
// LSB-first, keeps the carry chain locally and reassembles the registered sum stream.
module fa_serial_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_ci,
   output logic             fa_clr,
   input  logic             fa_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DRAIN,
      DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             fa_a_q;
   logic             fa_b_q;
   logic             fa_ci_q;
   logic             fa_clr_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_out_q;

   logic [WIDTH-1:0] b_d;
   logic             carry_d;

   // Subtraction is A + ~B + 1: invert B on entry and seed the carry with 1.
   assign b_d     = op_b ^ {WIDTH{sub}};
   assign carry_d = (fa_a_q & fa_b_q) | (fa_a_q & fa_ci_q) | (fa_b_q & fa_ci_q);

   // NOTE: all state updates are non-blocking so every register sees the
   // pre-edge values of the others, regardless of statement order.
   always_ff @(posedge ck) begin
      if (!rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         fa_a_q      <= 1'b0;
         fa_b_q      <= 1'b0;
         fa_ci_q     <= 1'b0;
         fa_clr_q    <= 1'b1;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  // Bit 0 goes straight to the adder pins; the rest wait in the shifters.
                  fa_a_q     <= op_a[0];
                  fa_b_q     <= b_d[0];
                  fa_ci_q    <= sub;
                  carry_q    <= sub;
                  a_q        <= op_a >> 1;
                  b_q        <= b_d >> 1;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  fa_clr_q   <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               fa_a_q  <= a_q[0];
               fa_b_q  <= b_q[0];
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_d;
               fa_ci_q <= (cnt_q == CNT_LAST) ? 1'b0 : carry_d;
               cnt_q   <= cnt_q + 1'b1;
               // fa_s lags the driven bits by one cycle, so cycle 0 carries no sum yet.
               if (cnt_q != '0) begin
                  result_q <= {fa_s, result_q[WIDTH-1:1]};
               end
               if (cnt_q == CNT_LAST) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               result_q    <= {fa_s, result_q[WIDTH-1:1]};
               carry_out_q <= carry_q;
               out_valid_q <= 1'b1;
               fa_clr_q    <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign fa_a      = fa_a_q;
   assign fa_b      = fa_b_q;
   assign fa_ci     = fa_ci_q;
   assign fa_clr    = fa_clr_q;

endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Directed and randomised bench for fa_serial_ctrl, closing the loop through a
// behavioural registered full adder.
module tb_fa_serial_ctrl;

   localparam int W = 8;

   logic         ck = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         sub = 1'b0;
   logic         fa_a;
   logic         fa_b;
   logic         fa_ci;
   logic         fa_clr;
   logic         fa_s;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         carry_out;

   int total = 0;
   int bad   = 0;

   always #5 ck = ~ck;

   fa_serial_ctrl #(.WIDTH(W)) dut (
      .ck        (ck),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .fa_a      (fa_a),
      .fa_b      (fa_b),
      .fa_ci     (fa_ci),
      .fa_clr    (fa_clr),
      .fa_s      (fa_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out)
   );

   // Registered full-adder cell: sum appears one cycle after its inputs.
   always_ff @(posedge ck) begin
      if (fa_clr) fa_s <= 1'b0;
      else        fa_s <= fa_a ^ fa_b ^ fa_ci;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W-1:0] diff;
      if (s) begin
         diff = a - b;
         return {(a >= b), diff};
      end
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Waits for in_ready, performs the handshake, then scrambles the operand bus.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_wait", 32'(n < 50), 32'd1);
      op_a     = a;
      op_b     = b;
      sub      = s;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op_a     = ~a;
      op_b     = ~b;
      sub      = ~s;
   endtask

   // Counts edges from the handshake until out_valid, recording fa_a/fa_ci per SHIFT cycle.
   task automatic wait_done(output int lat, output logic [W-1:0] a_seq, output logic [W-1:0] ci_seq);
      lat       = 0;
      a_seq     = '0;
      ci_seq    = '0;
      a_seq[0]  = fa_a;
      ci_seq[0] = fa_ci;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
         if (lat < W) begin
            a_seq[lat]  = fa_a;
            ci_seq[lat] = fa_ci;
         end
      end
   endtask

   task automatic consume(input int stall);
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int stall);
      int           lat;
      logic [W-1:0] a_seq;
      logic [W-1:0] ci_seq;
      logic [W:0]   exp;
      exp = model(a, b, s);
      start_op(a, b, s);
      wait_done(lat, a_seq, ci_seq);
      check({tag, "_latency"}, 32'(lat), 32'(W + 1));
      check({tag, "_result"}, 32'(result), 32'(exp[W-1:0]));
      check({tag, "_carry"}, 32'(carry_out), 32'(exp[W]));
      consume(stall);
      check({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int           lat;
      int           seen;
      logic [W-1:0] a_seq;
      logic [W-1:0] ci_seq;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;

      // Power-on reset.
      rst = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fa_clr", 32'(fa_clr), 32'd1);
      check("rst_result", 32'(result), 32'd0);
      check("rst_carry", 32'(carry_out), 32'd0);
      check("rst_fa_pins", {29'd0, fa_a, fa_b, fa_ci}, 32'd0);
      rst = 1'b1;
      tick();

      // Plain add with bit-stream and latency checks.
      start_op(8'h5A, 8'h3C, 1'b0);
      wait_done(lat, a_seq, ci_seq);
      check("add_latency", 32'(lat), 32'd9);
      check("add_fa_a_seq", 32'(a_seq), 32'h5A);
      check("add_result", 32'(result), 32'h96);
      check("add_carry", 32'(carry_out), 32'd0);
      check("add_done_fa_clr", 32'(fa_clr), 32'd1);
      check("add_done_in_ready", 32'(in_ready), 32'd0);
      consume(0);

      // Overflow: carry ripples through every bit.
      start_op(8'hFF, 8'h01, 1'b0);
      wait_done(lat, a_seq, ci_seq);
      check("ovf_fa_ci_seq", 32'(ci_seq), 32'hFE);
      check("ovf_result", 32'(result), 32'h00);
      check("ovf_carry", 32'(carry_out), 32'd1);
      consume(1);

      // Subtraction with and without borrow.
      run_op("sub_borrow", 8'h10, 8'h20, 1'b1, 0);
      check("sub_borrow_value", 32'(result), 32'hF0);
      run_op("sub_noborrow", 8'h20, 8'h10, 1'b1, 2);
      check("sub_noborrow_value", 32'(result), 32'h10);

      // Reset in the middle of SHIFT discards the operation.
      start_op(8'h12, 8'h34, 1'b0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_fa_clr", 32'(fa_clr), 32'd1);
      check("midrst_result", 32'(result), 32'd0);
      seen = 0;
      repeat (15) begin
         tick();
         if (out_valid) seen = 1;
      end
      check("midrst_no_out_valid", 32'(seen), 32'd0);

      // Backpressure with a second operand already pending.
      start_op(8'h33, 8'h44, 1'b0);
      wait_done(lat, a_seq, ci_seq);
      check("bp_first_result", 32'(result), 32'h77);
      op_a     = 8'h80;
      op_b     = 8'h80;
      sub      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_result", 32'(result), 32'h77);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      op_a     = 8'h00;
      op_b     = 8'h00;
      check("bp_second_accepted", 32'(in_ready), 32'd0);
      wait_done(lat, a_seq, ci_seq);
      check("bp_second_latency", 32'(lat), 32'd9);
      check("bp_second_result", 32'(result), 32'h00);
      check("bp_second_carry", 32'(carry_out), 32'd1);
      consume(0);

      // Random operands against the modulo model with random consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom_range(0, 1));
         run_op("rand", ra, rb, rs, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fa_serial_ctrl.md
Name: fa_serial_ctrl

Overview:
- Bit-serial driver/collector for the registered full-adder cell (`fa`).
- Accepts two parallel WIDTH-bit operands over a valid/ready handshake.
- Drives the adder LSB-first one bit per cycle, captures the registered sum bit stream back, and returns the parallel result plus carry/borrow.
- Carry chain is kept locally; the adder's `co` output is not used.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)

Ports:
ck          input   1      clock; all logic on rising edge
rst         input   1      synchronous, active-low reset
in_valid    input   1      operand request valid
in_ready    output  1      controller can accept operands
op_a        input   WIDTH  operand A
op_b        input   WIDTH  operand B
sub         input   1      1 = A−B (B inverted, initial carry 1); 0 = A+B
fa_a        output  1      serial A bit to adder `a`
fa_b        output  1      serial (possibly inverted) B bit to adder `b`
fa_ci       output  1      serial carry bit to adder `ci`
fa_clr      output  1      active-high clear to adder `rst`
fa_s        input   1      registered sum bit from adder (1-cycle latency)
out_valid   output  1      result valid
out_ready   input   1      consumer accepts result
result      output  WIDTH  sum/difference
carry_out   output  1      final carry (sub=1: 1 = no borrow)

Behaviour:
- Reset (rst=0 at edge), regardless of state:
  - Go to IDLE.
  - in_ready=1, out_valid=0, result=0, carry_out=0, fa_a=fa_b=fa_ci=0, fa_clr=1.
  - Bit counter and shift registers = 0.
  - A reset mid-operation discards the operation; no result is produced.
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE:
  - in_ready=1, fa_clr=1.
  - On in_valid&in_ready: latch op_a, op_b^{WIDTH{sub}}, carry=sub, cnt=0; go to SHIFT.
- SHIFT (WIDTH cycles, cnt 0..WIDTH−1):
  - in_ready=0, fa_clr=0.
  - fa_a/fa_b = LSB of the A/B shift registers; fa_ci = carry register. All three are registered outputs valid for the whole cycle.
  - Each edge:
    - carry ← maj(fa_a, fa_b, fa_ci).
    - Shift A/B right.
    - cnt++.
    - If cnt≥1, shift fa_s into result MSB (right-shift collect).
  - At cnt=WIDTH−1: go to DRAIN.
- DRAIN (1 cycle):
  - Capture the final fa_s into the result MSB.
  - carry_out ← carry register.
  - Go to DONE. fa_a/fa_b/fa_ci=0.
- Capture timing: sum bit i is driven in SHIFT cycle i and appears on fa_s in cycle i+1. Exactly WIDTH bits are captured, in cycles 1..WIDTH after SHIFT entry.
- DONE:
  - out_valid=1; result/carry_out held stable; fa_clr=1; in_ready=0.
  - On out_ready: out_valid←0, go to IDLE.
- Latency: handshake edge E → out_valid high after edge E+WIDTH+1 (WIDTH+2 cycles from handshake to first out_valid cycle). Throughput: one operation per WIDTH+3 cycles minimum.
- Arithmetic: modulo 2^WIDTH.
  - add: carry_out = bit WIDTH of A+B.
  - sub: carry_out = 1 iff A≥B (unsigned).
- Backpressure: out_ready low holds DONE indefinitely; new operands are not accepted until the result is consumed.
- in_valid while in_ready=0 is ignored; the source holds the request.
- op_a/op_b/sub changes after acceptance have no effect.

Test Plan:
- Reset: rst=0 for 2 cycles mid-SHIFT → next cycle in_ready=1, out_valid=0, fa_clr=1, result=0; no out_valid ever asserted for the aborted op.
- Add, WIDTH=8: A=0x5A, B=0x3C, sub=0, out_ready=1 → result=0x96, carry_out=0, out_valid exactly WIDTH+2 cycles after handshake; fa_a sequence 0,1,0,1,1,0,1,0.
- Add overflow: A=0xFF, B=0x01 → result=0x00, carry_out=1; fa_ci=1 during SHIFT cycles 1..7.
- Subtract: A=0x10, B=0x20, sub=1 → result=0xF0, carry_out=0. A=0x20, B=0x10 → result=0x10, carry_out=1.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles with in_valid=1 and a new operand pending → result stable, in_ready=0. Release out_ready → second op accepted in the IDLE cycle after and completes correctly.
- Scoreboard random: 1000 random A/B/sub with random out_ready stalls → every result matches the modulo model, using a behavioural `fa` with a registered sum.
